silent_stepper: RTL and testbench
=================================

SILENT_STEPPER -- requirements
Module: silent_stepper

Interface
REQ-001 Parameter DEPTH, default 249: number of channels per frame, minimum 8.
REQ-002 Parameter INTENSITY_WIDTH, default 16: intensity target/state width.
REQ-003 Parameter PHASE_WIDTH, default 16: phase target/state width; one full turn = 2^PHASE_WIDTH.
REQ-004 Parameter PHASE_OUT_WIDTH, default 8: output phase width, at most PHASE_WIDTH.
REQ-005 Port list (name, direction, width, meaning):
- CLK  in  1  sole clock.
- RST_N  in  1  asynchronous, active-low reset.
- DIN_VALID  in  1  high for each target channel beat.
- DIN_READY  out  1  block accepts frames.
- INTENSITY_IN  in  INTENSITY_WIDTH  unsigned target intensity.
- PHASE_IN  in  PHASE_WIDTH  target phase.
- UPDATE_RATE_INTENSITY  in  INTENSITY_WIDTH  maximum intensity step per frame.
- UPDATE_RATE_PHASE  in  PHASE_WIDTH  maximum phase step per frame.
- BYPASS  in  1  1 = jump directly to target.
- INTENSITY_OUT  out  INTENSITY_WIDTH  interpolated intensity.
- PHASE_OUT  out  PHASE_OUT_WIDTH  phase MSBs.
- DOUT_VALID  out  1  output beat valid.
- SETTLED  out  1  last frame reached every target.
- FRAME_ERR  out  1  one-cycle pulse on a truncated frame.

Function
REQ-006 The FSM SHALL have states INIT, IDLE and RUN; INIT SHALL write 0 to all DEPTH intensity and phase state entries, one entry per cycle, then go to IDLE; DIN_READY SHALL be 0 in INIT and 1 otherwise.
REQ-007 A frame SHALL be DEPTH consecutive cycles with DIN_VALID=1 while DIN_READY=1; beat k SHALL carry channel k; DIN_VALID while DIN_READY=0 SHALL be ignored.
REQ-008 UPDATE_RATE_INTENSITY, UPDATE_RATE_PHASE and BYPASS SHALL be latched on beat 0 and held for the whole frame.
REQ-009 Intensity: d = target - current, signed, INTENSITY_WIDTH+1 bits; step = clamp(d, -rate, +rate); next = current + step.
REQ-010 Phase: d = (target - current) mod 2^PHASE_WIDTH, interpreted in (-2^(PHASE_WIDTH-1), +2^(PHASE_WIDTH-1)]; an exact half-turn SHALL step positive; step = clamp(d, ±rate); next = (current + step) mod 2^PHASE_WIDTH.
REQ-011 BYPASS=1 SHALL set step = d (no clamp); rate = 0 with BYPASS=0 SHALL hold the current value.
REQ-012 For each channel, next SHALL be written back to state and output exactly LATENCY=4 cycles after its input beat; DOUT_VALID SHALL be high for exactly those beats, in channel order.
REQ-013 PHASE_OUT SHALL be next_phase[PHASE_WIDTH-1 -: PHASE_OUT_WIDTH]; INTENSITY_OUT SHALL be next_intensity.
REQ-014 A new frame MAY begin the cycle after beat DEPTH-1 (back-to-back); DIN_VALID held high continuously SHALL form successive frames.
REQ-015 If DIN_VALID drops before beat DEPTH-1, the block SHALL pulse FRAME_ERR for 1 cycle, return to IDLE, keep the state updates already made, and emit outputs only for beats that were received.
REQ-016 SETTLED SHALL update one cycle after the last output beat of a complete frame: 1 iff every channel's next equals its target; truncated frames SHALL NOT update it.

Reset
REQ-017 RST_N low SHALL force state INIT and DIN_READY=0, DOUT_VALID=0, FRAME_ERR=0, SETTLED=1, INTENSITY_OUT=0, PHASE_OUT=0, and SHALL clear all pipeline valids; a reset asserted mid-frame SHALL discard that frame.
REQ-018 After RST_N rises, INIT SHALL take DEPTH cycles; the state memory SHALL NOT itself be reset.

Structure
REQ-019 Package silent_pkg SHALL hold LATENCY and the state_t enum (INIT, IDLE, RUN).
REQ-020 The per-channel diff/wrap/clamp/add datapath SHALL be a sub-module, silent_step_calc, parametrised by width and a WRAP flag, instantiated once for intensity and once for phase.

Verification (DEPTH=8, widths 16/16/8)
REQ-021 After reset, check DIN_READY=0 for 8 cycles, then 1; a frame with all targets 0 -> outputs all 0 and SETTLED=1.
REQ-022 Channel 0 intensity target 1000 with rate 300 -> successive frames output 300, 600, 900, 1000; SETTLED=0, 0, 0, 1.
REQ-023 Channel 1 phase current 0xFF00, target 0x0100, rate 0x0080 -> 0xFF80, 0x0000, 0x0080, 0x0100 (forward wrap); PHASE_OUT 0xFF, 0x00, 0x00, 0x01.
REQ-024 Phase current 0, target 0x8000, rate 0xFFFF -> next 0x8000 via the positive step; with BYPASS=1 and intensity rate 0 -> intensity jumps to target in 1 frame.
REQ-025 DIN_VALID dropped after beat 4 -> FRAME_ERR pulse, 5 output beats, SETTLED unchanged; the next full frame is processed correctly.
REQ-026 Back-to-back frames with a rate change on the second frame's beat 0 -> the first frame uses the old rate and the second the new one; RST_N pulsed mid-frame -> DOUT_VALID=0 within the same cycle.

Source files
------------

// File: rtl/silent_pkg.sv
// Shared constants and FSM encoding for the silent_stepper frame interpolator.
package silent_pkg;
  localparam int LATENCY = 4;
  typedef enum logic [1:0] {INIT, IDLE, RUN} state_t;
endpackage

// File: rtl/silent_step_calc.sv
// One-channel rate-limited step: diff (optionally wrapped to a half-turn window),
// clamp to +/-rate unless bypassed, then add back onto the current value.
module silent_step_calc #(
  parameter int W    = 16,
  parameter bit WRAP = 1'b0
) (
  input  logic [W-1:0] i_cur,
  input  logic [W-1:0] i_tgt,
  input  logic [W-1:0] i_rate,
  input  logic         i_bypass,
  output logic [W-1:0] o_next
);
  logic signed [W:0] w_diff;
  logic signed [W:0] w_rate;
  logic signed [W:0] w_step;

  function automatic logic signed [W:0] clamp(input logic signed [W:0] d,
                                               input logic signed [W:0] r);
    if (d > r)       return r;
    else if (d < -r) return -r;
    else             return d;
  endfunction

  generate
    if (WRAP) begin : g_wrap
      logic [W-1:0] w_dmod;
      assign w_dmod = i_tgt - i_cur;
      // Exactly half a turn stays positive; anything beyond goes the short way back.
      assign w_diff = (w_dmod > {1'b1, {(W-1){1'b0}}}) ? $signed({1'b1, w_dmod})
                                                       : $signed({1'b0, w_dmod});
    end else begin : g_lin
      assign w_diff = $signed({1'b0, i_tgt}) - $signed({1'b0, i_cur});
    end
  endgenerate

  assign w_rate = $signed({1'b0, i_rate});
  assign w_step = i_bypass ? w_diff : clamp(w_diff, w_rate);
  assign o_next = i_cur + w_step[W-1:0];
endmodule

// File: rtl/silent_stepper.sv
// Per-channel intensity/phase interpolator: each frame moves every channel's state
// toward its target by at most the frame's rate, with a fixed 4-cycle beat latency.
module silent_stepper
  import silent_pkg::*;
#(
  parameter int DEPTH           = 249,
  parameter int INTENSITY_WIDTH = 16,
  parameter int PHASE_WIDTH     = 16,
  parameter int PHASE_OUT_WIDTH = 8
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic                       DIN_VALID,
  output logic                       DIN_READY,
  input  logic [INTENSITY_WIDTH-1:0] INTENSITY_IN,
  input  logic [PHASE_WIDTH-1:0]     PHASE_IN,
  input  logic [INTENSITY_WIDTH-1:0] UPDATE_RATE_INTENSITY,
  input  logic [PHASE_WIDTH-1:0]     UPDATE_RATE_PHASE,
  input  logic                       BYPASS,
  output logic [INTENSITY_WIDTH-1:0] INTENSITY_OUT,
  output logic [PHASE_OUT_WIDTH-1:0] PHASE_OUT,
  output logic                       DOUT_VALID,
  output logic                       SETTLED,
  output logic                       FRAME_ERR
);
  localparam int IW = INTENSITY_WIDTH;
  localparam int PW = PHASE_WIDTH;
  localparam int CW = $clog2(DEPTH);

  typedef struct packed {
    logic [CW-1:0] ch;
    logic [IW-1:0] tgt_i;
    logic [IW-1:0] rate_i;
    logic [PW-1:0] tgt_p;
    logic [PW-1:0] rate_p;
    logic          byp;
    logic          first;
    logic          last;
  } beat_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [IW-1:0] r_rate_i;
  logic [PW-1:0] r_rate_p;
  logic          r_byp;

  logic  w_acc, w_first, w_last;
  beat_t w_beat;
  beat_t r_beat_p0, r_beat_p1, r_beat_p2;
  logic  r_vld_p0, r_vld_p1, r_vld_p2;

  logic [IW-1:0] r_mem_i [DEPTH];
  logic [PW-1:0] r_mem_p [DEPTH];
  logic [IW-1:0] w_cur_i, w_next_i;
  logic [PW-1:0] w_cur_p, w_next_p;
  logic          w_eq;
  logic          r_acc, r_settle_upd;

  assign w_acc   = DIN_VALID && DIN_READY;
  assign w_first = w_acc && (r_state == IDLE);
  assign w_last  = w_acc && (r_state == RUN) && (r_cnt == CW'(DEPTH - 1));

  always_comb begin
    w_beat        = '0;
    w_beat.ch     = r_cnt;
    w_beat.tgt_i  = INTENSITY_IN;
    w_beat.tgt_p  = PHASE_IN;
    w_beat.rate_i = w_first ? UPDATE_RATE_INTENSITY : r_rate_i;
    w_beat.rate_p = w_first ? UPDATE_RATE_PHASE : r_rate_p;
    w_beat.byp    = w_first ? BYPASS : r_byp;
    w_beat.first  = w_first;
    w_beat.last   = w_last;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state   <= INIT;
      r_cnt     <= '0;
      DIN_READY <= 1'b0;
      FRAME_ERR <= 1'b0;
    end else begin
      FRAME_ERR <= 1'b0;
      case (r_state)
        INIT: begin
          if (r_cnt == CW'(DEPTH - 1)) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            DIN_READY <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        IDLE: begin
          if (DIN_VALID) begin
            r_state <= RUN;
            r_cnt   <= CW'(1);
          end
        end
        RUN: begin
          if (!DIN_VALID) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            FRAME_ERR <= 1'b1;
          end else if (r_cnt == CW'(DEPTH - 1)) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= INIT;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (w_first) begin
      r_rate_i <= UPDATE_RATE_INTENSITY;
      r_rate_p <= UPDATE_RATE_PHASE;
      r_byp    <= BYPASS;
    end
  end

  // p0 -> p1 -> p2: beat delay line; state is read and written only at the p2 edge,
  // so a later beat of the same channel always sees the previous write.
  always_ff @(posedge CLK) begin
    r_beat_p0 <= w_beat;
    r_beat_p1 <= r_beat_p0;
    r_beat_p2 <= r_beat_p1;
  end

  assign w_cur_i = r_mem_i[r_beat_p2.ch];
  assign w_cur_p = r_mem_p[r_beat_p2.ch];

  silent_step_calc #(.W(IW), .WRAP(1'b0)) u_calc_i (
    .i_cur    (w_cur_i),
    .i_tgt    (r_beat_p2.tgt_i),
    .i_rate   (r_beat_p2.rate_i),
    .i_bypass (r_beat_p2.byp),
    .o_next   (w_next_i)
  );

  silent_step_calc #(.W(PW), .WRAP(1'b1)) u_calc_p (
    .i_cur    (w_cur_p),
    .i_tgt    (r_beat_p2.tgt_p),
    .i_rate   (r_beat_p2.rate_p),
    .i_bypass (r_beat_p2.byp),
    .o_next   (w_next_p)
  );

  assign w_eq = (w_next_i == r_beat_p2.tgt_i) && (w_next_p == r_beat_p2.tgt_p);

  // p2 -> output: write-back and registered outputs.
  always_ff @(posedge CLK) begin
    if (r_state == INIT) begin
      r_mem_i[r_cnt] <= '0;
      r_mem_p[r_cnt] <= '0;
    end else if (r_vld_p2) begin
      r_mem_i[r_beat_p2.ch] <= w_next_i;
      r_mem_p[r_beat_p2.ch] <= w_next_p;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_vld_p0      <= 1'b0;
      r_vld_p1      <= 1'b0;
      r_vld_p2      <= 1'b0;
      DOUT_VALID    <= 1'b0;
      INTENSITY_OUT <= '0;
      PHASE_OUT     <= '0;
      r_acc         <= 1'b1;
      r_settle_upd  <= 1'b0;
      SETTLED       <= 1'b1;
    end else begin
      r_vld_p0     <= w_acc;
      r_vld_p1     <= r_vld_p0;
      r_vld_p2     <= r_vld_p1;
      DOUT_VALID   <= r_vld_p2;
      r_settle_upd <= r_vld_p2 && r_beat_p2.last;
      if (r_vld_p2) begin
        INTENSITY_OUT <= w_next_i;
        PHASE_OUT     <= w_next_p[PW-1 -: PHASE_OUT_WIDTH];
        r_acc         <= w_eq && (r_beat_p2.first || r_acc);
      end
      if (r_settle_upd) SETTLED <= r_acc;
    end
  end
endmodule

// File: tb/tb_silent_stepper.sv
// Directed bench for silent_stepper with DEPTH=8 and 16/16/8 widths.
module tb_silent_stepper;
  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        DIN_VALID = 1'b0;
  logic        DIN_READY;
  logic [15:0] INTENSITY_IN = '0;
  logic [15:0] PHASE_IN = '0;
  logic [15:0] UPDATE_RATE_INTENSITY = '0;
  logic [15:0] UPDATE_RATE_PHASE = '0;
  logic        BYPASS = 1'b0;
  logic [15:0] INTENSITY_OUT;
  logic [7:0]  PHASE_OUT;
  logic        DOUT_VALID, SETTLED, FRAME_ERR;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int err_cnt = 0;
  int first_cyc = 0;
  logic [15:0] tgt_i [8];
  logic [15:0] tgt_p [8];
  logic [15:0] q_i [$];
  logic [7:0]  q_p [$];
  int          q_t [$];

  always #5 CLK = ~CLK;

  silent_stepper #(
    .DEPTH(8), .INTENSITY_WIDTH(16), .PHASE_WIDTH(16), .PHASE_OUT_WIDTH(8)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .DIN_VALID(DIN_VALID), .DIN_READY(DIN_READY),
    .INTENSITY_IN(INTENSITY_IN), .PHASE_IN(PHASE_IN),
    .UPDATE_RATE_INTENSITY(UPDATE_RATE_INTENSITY), .UPDATE_RATE_PHASE(UPDATE_RATE_PHASE),
    .BYPASS(BYPASS), .INTENSITY_OUT(INTENSITY_OUT), .PHASE_OUT(PHASE_OUT),
    .DOUT_VALID(DOUT_VALID), .SETTLED(SETTLED), .FRAME_ERR(FRAME_ERR)
  );

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (DOUT_VALID === 1'b1) begin
      q_i.push_back(INTENSITY_OUT);
      q_p.push_back(PHASE_OUT);
      q_t.push_back(cyc);
    end
    if (FRAME_ERR === 1'b1) err_cnt = err_cnt + 1;
  end

  // Rates/bypass are only meaningful on beat 0; later beats carry junk.
  task automatic drive_frame(input int nbeats, input logic [15:0] ri,
                             input logic [15:0] rp, input logic byp);
    for (int k = 0; k < nbeats; k++) begin
      @(negedge CLK);
      if (k == 0) first_cyc = cyc;
      DIN_VALID             = 1'b1;
      INTENSITY_IN          = tgt_i[k];
      PHASE_IN              = tgt_p[k];
      UPDATE_RATE_INTENSITY = (k == 0) ? ri : 16'($urandom);
      UPDATE_RATE_PHASE     = (k == 0) ? rp : 16'($urandom);
      BYPASS                = (k == 0) ? byp : 1'($urandom);
    end
  endtask

  task automatic go_idle(input int n);
    @(negedge CLK);
    DIN_VALID = 1'b0;
    repeat (n - 1) @(negedge CLK);
  endtask

  task automatic test_reset();
    for (int k = 0; k < 8; k++) begin tgt_i[k] = '0; tgt_p[k] = '0; end
    RST_N = 1'b0;
    #12;
    checks++; if (DIN_READY !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b expected 0", DIN_READY); end
    checks++; if (DOUT_VALID !== 1'b0) begin errors++; $display("FAIL rst_dout_valid: got %b expected 0", DOUT_VALID); end
    checks++; if (FRAME_ERR !== 1'b0) begin errors++; $display("FAIL rst_frame_err: got %b expected 0", FRAME_ERR); end
    checks++; if (SETTLED !== 1'b1) begin errors++; $display("FAIL rst_settled: got %b expected 1", SETTLED); end
    checks++; if (INTENSITY_OUT !== 16'd0) begin errors++; $display("FAIL rst_intensity: got %0d expected 0", INTENSITY_OUT); end
    checks++; if (PHASE_OUT !== 8'd0) begin errors++; $display("FAIL rst_phase: got %0d expected 0", PHASE_OUT); end
    @(negedge CLK);
    RST_N = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      checks++; if (DIN_READY !== 1'b0) begin errors++; $display("FAIL init_ready c%0d: got %b expected 0", i, DIN_READY); end
      @(negedge CLK);
    end
    checks++; if (DIN_READY !== 1'b1) begin errors++; $display("FAIL init_done_ready: got %b expected 1", DIN_READY); end
  endtask

  task automatic test_zero_frame();
    int b;
    b = q_i.size();
    drive_frame(8, 16'd5, 16'd5, 1'b0);
    go_idle(8);
    checks++; if (q_i.size() - b != 8) begin errors++; $display("FAIL zero_beats: got %0d expected 8", q_i.size() - b); end
    for (int k = 0; k < 8; k++) begin
      checks++; if (q_i[b+k] !== 16'd0) begin errors++; $display("FAIL zero_i ch%0d: got %0d expected 0", k, q_i[b+k]); end
      checks++; if (q_p[b+k] !== 8'd0) begin errors++; $display("FAIL zero_p ch%0d: got %0d expected 0", k, q_p[b+k]); end
    end
    checks++; if (q_t[b] - first_cyc != 4) begin errors++; $display("FAIL latency: got %0d expected 4", q_t[b] - first_cyc); end
    checks++; if (SETTLED !== 1'b1) begin errors++; $display("FAIL zero_settled: got %b expected 1", SETTLED); end
  endtask

  task automatic test_intensity_ramp();
    int b;
    int exp_i [4] = '{300, 600, 900, 1000};
    logic exp_s [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    tgt_i[0] = 16'd1000;
    for (int f = 0; f < 4; f++) begin
      b = q_i.size();
      drive_frame(8, 16'd300, 16'd0, 1'b0);
      go_idle(8);
      checks++; if (q_i[b] !== 16'(exp_i[f])) begin errors++; $display("FAIL ramp_i f%0d: got %0d expected %0d", f, q_i[b], exp_i[f]); end
      checks++; if (SETTLED !== exp_s[f]) begin errors++; $display("FAIL ramp_settled f%0d: got %b expected %b", f, SETTLED, exp_s[f]); end
    end
    checks++; if (q_i[b+1] !== 16'd0) begin errors++; $display("FAIL ramp_ch1_i: got %0d expected 0", q_i[b+1]); end
  endtask

  task automatic test_phase_wrap();
    int b;
    logic [7:0] exp_p [4] = '{8'hFF, 8'h00, 8'h00, 8'h01};
    logic       exp_s [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    tgt_p[1] = 16'hFF00;
    b = q_i.size();
    drive_frame(8, 16'd0, 16'd0, 1'b1);
    go_idle(8);
    checks++; if (q_p[b+1] !== 8'hFF) begin errors++; $display("FAIL wrap_preset_p: got %0h expected ff", q_p[b+1]); end
    checks++; if (SETTLED !== 1'b1) begin errors++; $display("FAIL wrap_preset_settled: got %b expected 1", SETTLED); end
    tgt_p[1] = 16'h0100;
    for (int f = 0; f < 4; f++) begin
      b = q_i.size();
      drive_frame(8, 16'd0, 16'h0080, 1'b0);
      go_idle(8);
      checks++; if (q_p[b+1] !== exp_p[f]) begin errors++; $display("FAIL wrap_p f%0d: got %0h expected %0h", f, q_p[b+1], exp_p[f]); end
      checks++; if (SETTLED !== exp_s[f]) begin errors++; $display("FAIL wrap_settled f%0d: got %b expected %b", f, SETTLED, exp_s[f]); end
    end
  endtask

  task automatic test_half_turn();
    int b;
    tgt_p[2] = 16'h8000;
    b = q_i.size();
    drive_frame(8, 16'd0, 16'hFFFF, 1'b0);
    go_idle(8);
    checks++; if (q_p[b+2] !== 8'h80) begin errors++; $display("FAIL half_full_p: got %0h expected 80", q_p[b+2]); end
    checks++; if (q_p[b+1] !== 8'h01) begin errors++; $display("FAIL half_ch1_hold: got %0h expected 01", q_p[b+1]); end
    checks++; if (SETTLED !== 1'b1) begin errors++; $display("FAIL half_settled: got %b expected 1", SETTLED); end
    tgt_p[3] = 16'h8000;
    b = q_i.size();
    drive_frame(8, 16'd0, 16'h4000, 1'b0);
    go_idle(8);
    checks++; if (q_p[b+3] !== 8'h40) begin errors++; $display("FAIL half_dir_p: got %0h expected 40", q_p[b+3]); end
    checks++; if (q_p[b+2] !== 8'h80) begin errors++; $display("FAIL half_ch2_hold: got %0h expected 80", q_p[b+2]); end
    checks++; if (SETTLED !== 1'b0) begin errors++; $display("FAIL half_dir_settled: got %b expected 0", SETTLED); end
  endtask

  task automatic test_bypass_and_hold();
    int b;
    tgt_i[4] = 16'd12345;
    b = q_i.size();
    drive_frame(8, 16'd0, 16'd0, 1'b1);
    go_idle(8);
    checks++; if (q_i[b+4] !== 16'd12345) begin errors++; $display("FAIL bypass_i: got %0d expected 12345", q_i[b+4]); end
    checks++; if (q_p[b+3] !== 8'h80) begin errors++; $display("FAIL bypass_p: got %0h expected 80", q_p[b+3]); end
    checks++; if (SETTLED !== 1'b1) begin errors++; $display("FAIL bypass_settled: got %b expected 1", SETTLED); end
    tgt_i[5] = 16'd500;
    b = q_i.size();
    drive_frame(8, 16'd0, 16'd0, 1'b0);
    go_idle(8);
    checks++; if (q_i[b+5] !== 16'd0) begin errors++; $display("FAIL hold_i: got %0d expected 0", q_i[b+5]); end
    checks++; if (q_i[b+4] !== 16'd12345) begin errors++; $display("FAIL hold_ch4: got %0d expected 12345", q_i[b+4]); end
    checks++; if (SETTLED !== 1'b0) begin errors++; $display("FAIL hold_settled: got %b expected 0", SETTLED); end
  endtask

  task automatic test_truncated();
    int b, e0;
    tgt_i[0] = 16'd2000;
    b = q_i.size(); e0 = err_cnt;
    drive_frame(5, 16'd0, 16'd0, 1'b1);
    go_idle(8);
    checks++; if (q_i.size() - b != 5) begin errors++; $display("FAIL trunc_beats: got %0d expected 5", q_i.size() - b); end
    checks++; if (q_i[b] !== 16'd2000) begin errors++; $display("FAIL trunc_ch0: got %0d expected 2000", q_i[b]); end
    checks++; if (err_cnt - e0 != 1) begin errors++; $display("FAIL trunc_frame_err: got %0d cycles expected 1", err_cnt - e0); end
    checks++; if (SETTLED !== 1'b0) begin errors++; $display("FAIL trunc_settled: got %b expected 0", SETTLED); end
    checks++; if (DIN_READY !== 1'b1) begin errors++; $display("FAIL trunc_ready: got %b expected 1", DIN_READY); end
    b = q_i.size(); e0 = err_cnt;
    drive_frame(8, 16'd0, 16'd0, 1'b1);
    go_idle(8);
    checks++; if (q_i.size() - b != 8) begin errors++; $display("FAIL after_beats: got %0d expected 8", q_i.size() - b); end
    checks++; if (q_i[b] !== 16'd2000) begin errors++; $display("FAIL after_ch0: got %0d expected 2000", q_i[b]); end
    checks++; if (q_i[b+5] !== 16'd500) begin errors++; $display("FAIL after_ch5: got %0d expected 500", q_i[b+5]); end
    checks++; if (err_cnt - e0 != 0) begin errors++; $display("FAIL after_frame_err: got %0d cycles expected 0", err_cnt - e0); end
    checks++; if (SETTLED !== 1'b1) begin errors++; $display("FAIL after_settled: got %b expected 1", SETTLED); end
  endtask

  task automatic test_back_to_back();
    int b, c0;
    tgt_i[6] = 16'd1000;
    b = q_i.size();
    drive_frame(8, 16'd100, 16'd0, 1'b0);
    c0 = first_cyc;
    drive_frame(8, 16'd250, 16'd0, 1'b0);
    go_idle(8);
    checks++; if (q_i.size() - b != 16) begin errors++; $display("FAIL b2b_beats: got %0d expected 16", q_i.size() - b); end
    checks++; if (q_i[b+6] !== 16'd100) begin errors++; $display("FAIL b2b_f1_ch6: got %0d expected 100", q_i[b+6]); end
    checks++; if (q_i[b+14] !== 16'd350) begin errors++; $display("FAIL b2b_f2_ch6: got %0d expected 350", q_i[b+14]); end
    checks++; if (q_i[b+8] !== 16'd2000) begin errors++; $display("FAIL b2b_f2_ch0: got %0d expected 2000", q_i[b+8]); end
    checks++; if (q_t[b+15] - q_t[b] != 15) begin errors++; $display("FAIL b2b_span: got %0d expected 15", q_t[b+15] - q_t[b]); end
    checks++; if (q_t[b] - c0 != 4) begin errors++; $display("FAIL b2b_latency: got %0d expected 4", q_t[b] - c0); end
    checks++; if (SETTLED !== 1'b0) begin errors++; $display("FAIL b2b_settled: got %b expected 0", SETTLED); end
  endtask

  task automatic test_reset_mid_frame();
    int b;
    drive_frame(6, 16'd300, 16'd0, 1'b0);
    @(negedge CLK);
    checks++; if (DOUT_VALID !== 1'b1) begin errors++; $display("FAIL mid_pre_valid: got %b expected 1", DOUT_VALID); end
    #2 RST_N = 1'b0;
    #1;
    checks++; if (DOUT_VALID !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: got %b expected 0", DOUT_VALID); end
    checks++; if (DIN_READY !== 1'b0) begin errors++; $display("FAIL mid_rst_ready: got %b expected 0", DIN_READY); end
    checks++; if (SETTLED !== 1'b1) begin errors++; $display("FAIL mid_rst_settled: got %b expected 1", SETTLED); end
    checks++; if (INTENSITY_OUT !== 16'd0) begin errors++; $display("FAIL mid_rst_i: got %0d expected 0", INTENSITY_OUT); end
    DIN_VALID = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    b = q_i.size();
    repeat (8) @(negedge CLK);
    checks++; if (DIN_READY !== 1'b1) begin errors++; $display("FAIL mid_reinit_ready: got %b expected 1", DIN_READY); end
    drive_frame(8, 16'd300, 16'd0, 1'b0);
    go_idle(8);
    checks++; if (q_i.size() - b != 8) begin errors++; $display("FAIL mid_post_beats: got %0d expected 8", q_i.size() - b); end
    checks++; if (q_i[b] !== 16'd300) begin errors++; $display("FAIL mid_post_ch0: got %0d expected 300", q_i[b]); end
    checks++; if (q_i[b+6] !== 16'd300) begin errors++; $display("FAIL mid_post_ch6: got %0d expected 300", q_i[b+6]); end
    checks++; if (q_p[b+2] !== 8'h00) begin errors++; $display("FAIL mid_post_ch2_p: got %0h expected 00", q_p[b+2]); end
    checks++; if (SETTLED !== 1'b0) begin errors++; $display("FAIL mid_post_settled: got %b expected 0", SETTLED); end
  endtask

  initial begin
    test_reset();
    test_zero_frame();
    test_intensity_ramp();
    test_phase_wrap();
    test_half_turn();
    test_bypass_and_hold();
    test_truncated();
    test_back_to_back();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
